// File: rtl/cache_axi_bridge.sv
// cache_axi_bridge: arbitrates cache/uncached read clients and one write client onto an AXI-style master
// Ports:
//   clk, rst                  clock, synchronous active-high reset
//   rd_req_i/rd_addr_i/rd_uncached_i -> rd_valid_o/rd_line_o/rd_word_o   read clients (index 0 highest priority)
//   wr_req_i/wr_uncached_i/wr_addr_i/wr_line_i -> wr_done_o             write client
//   axi_ren_o/axi_rready_o/axi_raddr_o/axi_rlen_o, rdata_i/rdata_valid_i AXI read side
//   axi_wen_o/axi_wvalid_o/axi_waddr_o/axi_wdata_o/axi_wlast_o/axi_wlen_o, wdata_resp_i  AXI write side
// Define CACHE_AXI_RR_ARB_EN for round-robin read arbitration; fixed priority otherwise.
module cache_axi_bridge #(
  parameter int NUM_RD = 3,
  parameter int LINE_W = 8,
  parameter int ADDR_W = 32,
  parameter int DATA_W = 32
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic [NUM_RD-1:0]        rd_req_i,
  input  logic [NUM_RD*ADDR_W-1:0] rd_addr_i,
  input  logic [NUM_RD-1:0]        rd_uncached_i,
  output logic [NUM_RD-1:0]        rd_valid_o,
  output logic [LINE_W*DATA_W-1:0] rd_line_o,
  output logic [DATA_W-1:0]        rd_word_o,
  input  logic                     wr_req_i,
  input  logic                     wr_uncached_i,
  input  logic [ADDR_W-1:0]        wr_addr_i,
  input  logic [LINE_W*DATA_W-1:0] wr_line_i,
  output logic                     wr_done_o,
  output logic                     axi_ren_o,
  output logic                     axi_rready_o,
  output logic [ADDR_W-1:0]        axi_raddr_o,
  output logic [3:0]               axi_rlen_o,
  input  logic [DATA_W-1:0]        rdata_i,
  input  logic                     rdata_valid_i,
  output logic                     axi_wen_o,
  output logic                     axi_wvalid_o,
  output logic [ADDR_W-1:0]        axi_waddr_o,
  output logic [DATA_W-1:0]        axi_wdata_o,
  output logic                     axi_wlast_o,
  output logic [3:0]               axi_wlen_o,
  input  logic                     wdata_resp_i
);
  localparam int GW = NUM_RD > 1 ? $clog2(NUM_RD) : 1;
  localparam int LW = $clog2(LINE_W);
  typedef enum logic [1:0] {R_IDLE, R_BUSY, R_DONE} r_state_t;
  typedef enum logic [1:0] {W_IDLE, W_BUSY, W_DONE} w_state_t;
  r_state_t rs;
  w_state_t ws;
  logic [GW-1:0] grant, pick, idx;
  logic [ADDR_W-1:0] raddr, waddr;
  logic runc, wunc;
  logic [LW-1:0] rc, wc, wsel;
  logic [LINE_W*DATA_W-1:0] wline;
`ifdef CACHE_AXI_RR_ARB_EN
  logic [GW-1:0] rr_ptr;
  always_ff @(posedge clk)
    if (rst) rr_ptr <= GW'(NUM_RD - 1);
    else if (rs == R_IDLE && |rd_req_i) rr_ptr <= pick;
`endif
  // Scan from lowest to highest priority so the highest-priority requester is written last.
  always_comb begin
    pick = '0;
    idx = '0;
    for (int k = NUM_RD - 1; k >= 0; k--) begin
`ifdef CACHE_AXI_RR_ARB_EN
      idx = GW'((int'(rr_ptr) + 1 + k) % NUM_RD);
`else
      idx = GW'(k);
`endif
      if (rd_req_i[idx]) pick = idx;
    end
  end
  always_ff @(posedge clk)
    if (rst) begin
      rs <= R_IDLE;
      grant <= '0;
      raddr <= '0;
      runc <= 1'b0;
      rc <= '0;
      rd_line_o <= '0;
      rd_word_o <= '0;
    end else
      case (rs)
        R_IDLE: if (|rd_req_i) begin
          rs <= R_BUSY;
          grant <= pick;
          raddr <= rd_addr_i[pick*ADDR_W +: ADDR_W];
          runc <= rd_uncached_i[pick];
          rc <= '0;
        end
        R_BUSY: if (rdata_valid_i) begin
          rd_line_o[rc*DATA_W +: DATA_W] <= rdata_i;
          rd_word_o <= rdata_i;
          rc <= rc + 1'b1;
          if (runc || rc == LW'(LINE_W - 1)) rs <= R_DONE;
        end
        default: rs <= R_IDLE;
      endcase
  assign rd_valid_o   = rs == R_DONE ? NUM_RD'(1) << grant : '0;
  assign axi_ren_o    = rs == R_BUSY;
  assign axi_rready_o = axi_ren_o;
  assign axi_raddr_o  = !axi_ren_o ? '0 : runc ? raddr : {raddr[ADDR_W-1:LW+2], rc, 2'b00};
  assign axi_rlen_o   = runc ? 4'd0 : 4'(LINE_W - 1);
  always_ff @(posedge clk)
    if (rst) begin
      ws <= W_IDLE;
      waddr <= '0;
      wunc <= 1'b0;
      wc <= '0;
      wline <= '0;
    end else
      case (ws)
        W_IDLE: if (wr_req_i) begin
          ws <= W_BUSY;
          waddr <= wr_addr_i;
          wunc <= wr_uncached_i;
          wline <= wr_line_i;
          wc <= '0;
        end
        W_BUSY: if (wdata_resp_i) begin
          wc <= wc + 1'b1;
          if (axi_wlast_o) ws <= W_DONE;
        end
        default: ws <= W_IDLE;
      endcase
  assign wsel         = wunc ? '0 : wc;
  assign wr_done_o    = ws == W_DONE;
  assign axi_wen_o    = ws == W_BUSY;
  assign axi_wvalid_o = axi_wen_o;
  assign axi_waddr_o  = !axi_wen_o ? '0 : wunc ? waddr : {waddr[ADDR_W-1:LW+2], wc, 2'b00};
  assign axi_wdata_o  = wline[wsel*DATA_W +: DATA_W];
  assign axi_wlast_o  = axi_wen_o && (wunc || wc == LW'(LINE_W - 1));
  assign axi_wlen_o   = wunc ? 4'd0 : 4'(LINE_W - 1);
endmodule

// File: tb/tb_cache_axi_bridge.sv
// tb_cache_axi_bridge: table-driven, directed and randomized checks of cache_axi_bridge
module tb_cache_axi_bridge;
  logic clk = 1'b0, rst = 1'b1;
  logic [2:0] rd_req, rd_unc, rd_valid;
  logic [95:0] rd_addr;
  logic [255:0] rd_line, wr_line;
  logic [31:0] rd_word, wr_addr, axi_raddr, rdata, axi_waddr, axi_wdata;
  logic wr_req, wr_unc, wr_done, axi_ren, axi_rready, rdata_valid;
  logic axi_wen, axi_wvalid, axi_wlast, wdata_resp;
  logic [3:0] axi_rlen, axi_wlen;
  int checks = 0, fails = 0;
  always #5 clk = ~clk;
  cache_axi_bridge dut (
    .clk(clk), .rst(rst),
    .rd_req_i(rd_req), .rd_addr_i(rd_addr), .rd_uncached_i(rd_unc),
    .rd_valid_o(rd_valid), .rd_line_o(rd_line), .rd_word_o(rd_word),
    .wr_req_i(wr_req), .wr_uncached_i(wr_unc), .wr_addr_i(wr_addr), .wr_line_i(wr_line),
    .wr_done_o(wr_done),
    .axi_ren_o(axi_ren), .axi_rready_o(axi_rready), .axi_raddr_o(axi_raddr), .axi_rlen_o(axi_rlen),
    .rdata_i(rdata), .rdata_valid_i(rdata_valid),
    .axi_wen_o(axi_wen), .axi_wvalid_o(axi_wvalid), .axi_waddr_o(axi_waddr), .axi_wdata_o(axi_wdata),
    .axi_wlast_o(axi_wlast), .axi_wlen_o(axi_wlen), .wdata_resp_i(wdata_resp)
  );
  typedef struct {
    int cli;
    logic [31:0] addr;
    bit unc;
    logic [31:0] d0;
    logic [31:0] a0;
    logic [3:0] rlen;
  } rvec_t;
  rvec_t tbl[4];
  // reference model: transaction-level view of both channels
  int r_left, r_beat, r_cli, rr_last, w_left, w_beat, n_rdv, n_wdone;
  bit r_pulse, r_unc, w_pulse, w_unc;
  logic [31:0] r_addr, w_addr, m_word;
  logic [31:0] m_line[8], w_data[8];
  task automatic chk(input string n, input logic [255:0] a, input logic [255:0] e);
    checks++;
    if (a !== e) begin
      fails++;
      $display("FAIL %s: got %0h expected %0h", n, a, e);
    end
  endtask
  task automatic tick();
    @(posedge clk);
    #1;
  endtask
  task automatic model_reset();
    r_left = 0; r_pulse = 0; w_left = 0; w_pulse = 0; rr_last = 2; m_word = 0;
    for (int i = 0; i < 8; i++) m_line[i] = 0;
  endtask
  task automatic do_reset();
    rst = 1; rd_req = 0; rd_unc = 0; rd_addr = 0; wr_req = 0; wr_unc = 0; wr_addr = 0;
    wr_line = 0; rdata = 0; rdata_valid = 0; wdata_resp = 0;
    tick(); tick();
    rst = 0;
    model_reset();
  endtask
  task automatic do_read(input rvec_t v);
    int n, beats;
    logic [255:0] exp_line;
    rd_req = 0;
    rd_req[v.cli] = 1;
    rd_addr[v.cli*32 +: 32] = v.addr;
    rd_unc[v.cli] = v.unc;
    n = 0;
    do begin tick(); n++; end while (!axi_ren && n < 10);
    chk("rd_busy", axi_ren, 1);
    chk("rlen", axi_rlen, v.rlen);
    beats = v.unc ? 1 : 8;
    exp_line = 0;
    for (int i = 0; i < beats; i++) begin
      chk("raddr_beat", axi_raddr, v.a0 + 32'(4 * i));
      exp_line[i*32 +: 32] = v.d0 + 32'(i);
      rdata = v.d0 + 32'(i);
      rdata_valid = 1;
      tick();
      rdata_valid = 0;
    end
    chk("rd_valid", rd_valid, 3'b1 << v.cli);
    if (v.unc) chk("rd_word", rd_word, v.d0);
    else chk("rd_line", rd_line, exp_line);
    rd_req = 0;
    tick();
    chk("rd_valid_one_cycle", {axi_ren, rd_valid}, 0);
  endtask
  task automatic run_engine(input int ncyc, input bit rnd);
    logic [255:0] exp_line;
    n_rdv = 0; n_wdone = 0;
    for (int c = 0; c < ncyc; c++) begin
      for (int k = 0; k < 3; k++) if (r_pulse && r_cli == k) rd_req[k] = 0;
      if (w_pulse) wr_req = 0;
      if (rnd) begin
        for (int k = 0; k < 3; k++)
          if (!rd_req[k] && !(r_pulse && r_cli == k) && $urandom_range(3) == 0) begin
            rd_req[k] = 1;
            rd_addr[k*32 +: 32] = $urandom;
            rd_unc[k] = 1'($urandom_range(1));
          end
        if (r_left > 0) begin
          rd_addr[r_cli*32 +: 32] = $urandom;
          rd_unc[r_cli] = 1'($urandom_range(1));
        end
        if (!wr_req && !w_pulse && $urandom_range(3) == 0) begin
          wr_req = 1; wr_addr = $urandom; wr_unc = 1'($urandom_range(1));
          for (int i = 0; i < 8; i++) wr_line[i*32 +: 32] = $urandom;
        end
        if (w_left > 0) begin
          wr_addr = $urandom;
          wr_line[31:0] = $urandom;
          wr_unc = 1'($urandom_range(1));
        end
        rdata_valid = 1'($urandom_range(1));
        rdata = $urandom;
        wdata_resp = 1'($urandom_range(1));
      end else begin
        if (c == 0) begin
          rd_req = 3'b001; rd_unc = 0; rd_addr[31:0] = 32'h3000_0010;
          wr_req = 1; wr_unc = 0; wr_addr = 32'h2000_0000;
          for (int i = 0; i < 8; i++) wr_line[i*32 +: 32] = 32'h10 + 32'(i);
        end
        rdata_valid = 1;
        rdata = 32'hB0 + 32'(r_beat);
        wdata_resp = (c % 2) == 1;
      end
      tick();
      if (r_pulse) r_pulse = 0;
      else if (r_left > 0) begin
        if (rdata_valid) begin
          m_line[r_beat] = rdata; m_word = rdata;
          r_beat++; r_left--;
          r_pulse = r_left == 0;
        end
      end else if (rd_req != 0) begin
`ifdef CACHE_AXI_RR_ARB_EN
        for (int k = 1; k <= 3; k++) if (rd_req[(rr_last + k) % 3]) begin r_cli = (rr_last + k) % 3; break; end
`else
        for (int k = 0; k < 3; k++) if (rd_req[k]) begin r_cli = k; break; end
`endif
        rr_last = r_cli;
        r_addr = rd_addr[r_cli*32 +: 32];
        r_unc = rd_unc[r_cli];
        r_left = r_unc ? 1 : 8;
        r_beat = 0;
      end
      if (w_pulse) w_pulse = 0;
      else if (w_left > 0) begin
        if (wdata_resp) begin
          w_beat++; w_left--;
          w_pulse = w_left == 0;
        end
      end else if (wr_req) begin
        w_addr = wr_addr; w_unc = wr_unc;
        for (int i = 0; i < 8; i++) w_data[i] = wr_line[i*32 +: 32];
        w_left = w_unc ? 1 : 8;
        w_beat = 0;
      end
      chk("ren", {axi_ren, axi_rready}, {2{r_left > 0}});
      chk("raddr", axi_raddr, r_left == 0 ? 32'h0 : r_unc ? r_addr : (r_addr & ~32'h1F) + 32'(4 * r_beat));
      if (r_left > 0) chk("rlen", axi_rlen, r_unc ? 4'd0 : 4'd7);
      chk("rd_valid", rd_valid, r_pulse ? 3'b1 << r_cli : 3'b0);
      if (r_pulse) begin
        n_rdv++;
        if (r_unc) chk("rd_word", rd_word, m_word);
        else begin
          for (int i = 0; i < 8; i++) exp_line[i*32 +: 32] = m_line[i];
          chk("rd_line", rd_line, exp_line);
        end
      end
      chk("wen", {axi_wen, axi_wvalid}, {2{w_left > 0}});
      if (w_left > 0) begin
        chk("waddr", axi_waddr, w_unc ? w_addr : (w_addr & ~32'h1F) + 32'(4 * w_beat));
        chk("wdata", axi_wdata, w_data[w_unc ? 0 : w_beat]);
        chk("wlast", axi_wlast, w_left == 1);
        chk("wlen", axi_wlen, w_unc ? 4'd0 : 4'd7);
      end
      chk("wr_done", wr_done, w_pulse);
      if (w_pulse) n_wdone++;
    end
  endtask
  initial begin
    int n, exp_cli;
    tbl[0] = '{1, 32'h1000_0044, 1'b0, 32'hA0, 32'h1000_0040, 4'd7};
    tbl[1] = '{2, 32'hBFC0_0004, 1'b1, 32'hDEAD_BEEF, 32'hBFC0_0004, 4'd0};
    tbl[2] = '{0, 32'h8000_007C, 1'b0, 32'h100, 32'h8000_0060, 4'd7};
    tbl[3] = '{0, 32'h1234_5678, 1'b1, 32'h5555_AAAA, 32'h1234_5678, 4'd0};
    do_reset();
    chk("reset_ctrl", {axi_ren, axi_rready, axi_wen, axi_wvalid, rd_valid, wr_done, axi_wlast}, 0);
    chk("reset_data", {rd_line, rd_word, axi_raddr}, 0);
    for (int t = 0; t < 4; t++) do_read(tbl[t]);
    // T3: all three clients request continuously
    do_reset();
    rd_req = 3'b111; rd_unc = 3'b111;
    for (int k = 0; k < 3; k++) rd_addr[k*32 +: 32] = 32'h4000_0000 + 32'(k * 16);
    for (int g = 0; g < 3; g++) begin
`ifdef CACHE_AXI_RR_ARB_EN
      exp_cli = g;
`else
      exp_cli = 0;
`endif
      n = 0;
      do begin tick(); n++; end while (!axi_ren && n < 10);
      chk("t3_busy", axi_ren, 1);
      chk("t3_grant_addr", axi_raddr, 32'h4000_0000 + 32'(exp_cli * 16));
      rdata = 32'(g); rdata_valid = 1;
      tick();
      rdata_valid = 0;
      chk("t3_valid", rd_valid, 3'b1 << exp_cli);
      tick();
      chk("t3_no_regrant", {axi_ren, rd_valid}, 0);
    end
    rd_req = 0;
    // T5: reset in the middle of a burst
    do_reset();
    rd_req = 3'b010; rd_unc = 0; rd_addr[63:32] = 32'h1000_0044;
    tick();
    rdata_valid = 1;
    for (int i = 0; i < 3; i++) begin rdata = 32'hC0 + 32'(i); tick(); end
    rdata_valid = 0; rst = 1;
    tick();
    chk("t5_abort", {axi_ren, rd_valid}, 0);
    chk("t5_line_clear", rd_line, 0);
    rst = 0; rd_req = 0;
    tick();
    chk("t5_no_pulse", rd_valid, 0);
    do_read(tbl[0]);
    // T6: stray beats and acknowledges while idle
    rdata_valid = 1; wdata_resp = 1; rdata = 32'h777;
    for (int i = 0; i < 4; i++) begin
      tick();
      chk("t6_idle", {axi_ren, axi_wen, rd_valid, wr_done}, 0);
    end
    rdata_valid = 0; wdata_resp = 0;
    do_read(tbl[2]);
    // T4: cached write concurrent with a client 0 read
    do_reset();
    run_engine(40, 1'b0);
    chk("t4_rd_pulses", n_rdv, 1);
    chk("t4_wr_pulses", n_wdone, 1);
    do_reset();
    run_engine(3000, 1'b1);
    chk("rand_progress", n_rdv > 20 && n_wdone > 20, 1);
    $display("TB_RESULT checks=%0d failures=%0d", checks, fails);
    $finish;
  end
endmodule
